// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell plus a borrow
// flip-flop computes a - b LSB first, framed by a start/busy/done handshake.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] sa, sb, sr;
    logic [CW-1:0]    cnt;
    logic             bf;
    logic             a_msb, b_msb;

    logic d0, b0, d, b1, last;

    // Full subtractor built from two half-subtractors; borrow is the OR of both.
    always_comb begin
        d0   = sa[0] ^ sb[0];
        b0   = ~sa[0] & sb[0];
        d    = d0 ^ bf;
        b1   = ~d0 & bf;
        last = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            cnt        <= '0;
            bf         <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        bf    <= 1'b0;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    bf  <= b0 | b1;
                    sr  <= {d, sr[WIDTH-1:1]};
                    sa  <= {1'b0, sa[WIDTH-1:1]};
                    sb  <= {1'b0, sb[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    // The last bit's d is merged directly so diff never shows a partial value.
                    if (last) begin
                        diff       <= {d, sr[WIDTH-1:1]};
                        borrow_out <= b0 | b1;
                        ovf        <= (a_msb ^ b_msb) & (a_msb ^ d);
                        done       <= 1'b1;
                        busy       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=8); outputs sampled on negedge.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, borrow_out, ovf;
    logic [7:0] diff;

    int checks = 0;
    int errors = 0;

    logic [7:0] held_diff;
    logic       held_borrow, held_ovf;

    serial_sub #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at a negedge with start=1 already driven; the next posedge is E0.
    // inject: RUN cycle index at which a stray start (na/nb) is pulsed, -1 for none.
    // chain: leave start asserted with na/nb in the done cycle.
    task automatic track(input string tag, input logic [7:0] ed, input logic eb, input logic eo,
                         input int inject, input bit chain,
                         input logic [7:0] na, input logic [7:0] nb);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk({tag, " busy"}, busy, 1'b1);
            chk({tag, " done_low"}, done, 1'b0);
            chk({tag, " diff_held"}, {borrow_out, ovf, diff}, {held_borrow, held_ovf, held_diff});
            if (k == inject) begin
                start = 1'b1;
                a = na;
                b = nb;
            end else begin
                start = 1'b0;
                a = 8'($urandom);
                b = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " busy_low"}, busy, 1'b0);
        chk({tag, " diff"}, diff, ed);
        chk({tag, " borrow"}, borrow_out, eb);
        chk({tag, " ovf"}, ovf, eo);
        held_diff   = ed;
        held_borrow = eb;
        held_ovf    = eo;
        if (chain) begin
            start = 1'b1;
            a = na;
            b = nb;
        end else begin
            start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk({tag, " done_drop"}, done, 1'b0);
            chk({tag, " idle_busy"}, busy, 1'b0);
            chk({tag, " result_held"}, {borrow_out, ovf, diff}, {eb, eo, ed});
        end
    endtask

    task automatic launch(input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        start = 1'b1;
        a = va;
        b = vb;
    endtask

    initial begin
        int seen_done;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        held_diff = '0;
        held_borrow = 1'b0;
        held_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {busy, done, borrow_out, ovf, diff}, 12'h000);
        rst = 1'b0;

        launch(8'd100, 8'd37);
        track("basic", 8'h3F, 1'b0, 1'b0, -1, 1'b0, 8'd0, 8'd0);
        launch(8'd37, 8'd100);
        track("borrow", 8'hC1, 1'b1, 1'b0, -1, 1'b0, 8'd0, 8'd0);
        launch(8'h80, 8'h01);
        track("ovf_neg", 8'h7F, 1'b0, 1'b1, -1, 1'b0, 8'd0, 8'd0);
        launch(8'h7F, 8'hFF);
        track("ovf_pos", 8'h80, 1'b1, 1'b1, -1, 1'b0, 8'd0, 8'd0);
        launch(8'd0, 8'd0);
        track("zero", 8'h00, 1'b0, 1'b0, -1, 1'b0, 8'd0, 8'd0);

        // Stray start during RUN is dropped; start in the done cycle is accepted.
        launch(8'd100, 8'd37);
        track("ignore", 8'h3F, 1'b0, 1'b0, 3, 1'b1, 8'd5, 8'd3);
        track("chain", 8'h02, 1'b0, 1'b0, -1, 1'b0, 8'd0, 8'd0);

        launch(8'd100, 8'd37);
        track("pre_rst", 8'h3F, 1'b0, 1'b0, -1, 1'b0, 8'd0, 8'd0);
        launch(8'd37, 8'd100);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst outputs", {busy, done, borrow_out, ovf, diff}, 12'h000);
        seen_done = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        chk("mid_rst no_done", seen_done, 0);
        chk("mid_rst still_zero", {borrow_out, ovf, diff}, 10'h000);
        held_diff = '0;
        held_borrow = 1'b0;
        held_ovf = 1'b0;
        launch(8'd100, 8'd37);
        track("post_rst", 8'h3F, 1'b0, 1'b0, -1, 1'b0, 8'd0, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial two's-complement subtractor. It computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell (two half-subtractors plus an OR for borrow) and a borrow flip-flop. It is the subtraction counterpart of the team's full-adder datapath cells and trades latency for area in arithmetic units. A start/busy/done handshake frames each operation.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a new operation. Sampled only in IDLE.
- `a` input WIDTH: minuend, captured on the edge that accepts `start`.
- `b` input WIDTH: subtrahend, captured on the same edge as `a`.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse marking a valid new result.
- `diff` output WIDTH: result `(a - b) mod 2^WIDTH`. Registered and held until the next completion.
- `borrow_out` output 1: final borrow, 1 iff unsigned `a < b`. Held like `diff`.
- `ovf` output 1: signed overflow flag. Held like `diff`.

## Operation
- States: IDLE and RUN. `done` is a registered pulse, not a separate state.
- **IDLE, `start`=1 at an edge:**
  - Load shift registers `sa`=`a`, `sb`=`b`.
  - Clear the borrow flip-flop `bf` and clear `cnt`.
  - Latch `a[WIDTH-1]` and `b[WIDTH-1]` for the overflow calculation.
  - Set `busy`=1, clear `done`, go to RUN.
- **IDLE, `start`=0:** hold all state. Clear `done` if it is set.
- **RUN, each edge:**
  - Half-subtractor 0: `d0 = sa[0]^sb[0]`, `b0 = ~sa[0]&sb[0]`.
  - Half-subtractor 1: `d = d0^bf`, `b1 = ~d0&bf`.
  - Update the borrow: `bf <= b0|b1`.
  - Shift `d` into the MSB of the internal result shift register `sr`.
  - Shift `sa` and `sb` right by one. Increment `cnt`.
- **RUN, edge where `cnt`=WIDTH-1 (last bit):**
  - `diff <=` final `sr` value, including this cycle's `d`.
  - `borrow_out <= b0|b1`.
  - `ovf <= (a_msb^b_msb) & (a_msb^d)`.
  - `done <= 1`, `busy <= 0`, go to IDLE.
- **`start` while RUN:** ignored and not queued. The operands on `a`/`b` are also ignored.
- **`start` in the cycle `done`=1:** the FSM is already in IDLE, so the request is accepted. `done` drops on that edge and `busy` rises.
- **`a`/`b` after capture:** they may change freely; the result depends only on the captured values.
- **Counter:** `cnt` is `$clog2(WIDTH)` bits wide and is never compared beyond WIDTH-1, so it does not wrap inside RUN.
- **Reset:**
  - Values: `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `ovf`=0. The FSM goes to IDLE and all internal registers clear.
  - Reset mid-RUN aborts the operation. No `done` is produced and the previous result is lost (outputs read 0).
  - Reset has priority over `start` on the same edge.

## Timing
- **Edges of one operation:** E0 accepts `start`. Edges E1..EWIDTH process bits 0..WIDTH-1.
- **Result valid:** `done`=1 and the new `diff`/`borrow_out`/`ovf` are visible in the cycle after EWIDTH.
- **`busy`:** high from the cycle after E0 through the cycle after EWIDTH-1, which is exactly WIDTH cycles.
- **`done`:** high for exactly one cycle, then cleared at EWIDTH+1.
- **Latency:** from the `start` sample to `done` high is WIDTH+1 edges.
- **Throughput:** the next `start` can be accepted at EWIDTH+1. That gives one result per WIDTH+1 cycles, back-to-back.
- **Held outputs:** `diff`, `borrow_out` and `ovf` change only at the completion edge or at reset. They never show partial values.
- **No combinational paths** from inputs to outputs.

## Test plan
- **Basic subtraction:** WIDTH=8, `a`=100, `b`=37, one-cycle `start`.
  - `done` pulses 9 edges after the start edge.
  - `diff`=63 (0x3F), `borrow_out`=0, `ovf`=0.
  - `busy` is high for 8 cycles.
- **Borrow:** `a`=37, `b`=100.
  - `diff`=0xC1, `borrow_out`=1, `ovf`=0.
- **Signed overflow:** `a`=0x80, `b`=0x01.
  - `diff`=0x7F, `borrow_out`=0, `ovf`=1.
- **Zero operands:** `a`=`b`=0.
  - `diff`=0, `borrow_out`=0, `ovf`=0.
  - `done` still pulses after 9 edges.
- **Start while busy and back-to-back:**
  - Run 100-37. Assert `start` with 5-3 during RUN: it is ignored, and the first result is 63 on schedule.
  - Then assert `start` with 5-3 in the `done` cycle: it is accepted, and `diff`=2 after a further 9 edges.
- **Reset mid-operation:**
  - Complete 100-37 (`diff`=63). Start 37-100 and assert `rst` at E4.
  - All outputs read 0 on the next cycle and no `done` is seen.
  - A new 100-37 afterwards completes normally with `diff`=63.
